// File: rtl/la_aopipe.sv
// la_aopipe: N-term AND-OR / OR-AND reduction followed by a STAGES-deep
// valid/ready register pipeline with full backpressure.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   nreset     asynchronous active-low reset, clears every stage
//   in_valid   input transaction valid
//   in_ready   block accepts the input transaction this cycle
//   mode       0: z = OR_i (a_i & b_i), 1: z = AND_i (a_i | b_i)
//   a, b       N packed operand terms, term i = x[i*DW +: DW]
//   out_valid  result valid (last stage valid bit)
//   out_ready  downstream accepts the result
//   z          reduction result (last stage data register)
//
// PROP is an implementation property string carried for compatibility; it
// has no functional effect.
module la_aopipe #(
    parameter int N      = 3,
    parameter int DW     = 1,
    parameter int STAGES = 2,
    parameter     PROP   = "DEFAULT"
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mode,
    input  logic [N*DW-1:0] a,
    input  logic [N*DW-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   z
);

    logic [DW-1:0]             red;
    logic [STAGES-1:0]         v_q;
    logic [STAGES-1:0][DW-1:0] d_q;
    logic [STAGES:0]           rdy;
    logic [STAGES-1:0]         load;
    logic [STAGES-1:0]         drain;
    logic [STAGES-1:0][DW-1:0] din;
    logic                      all_full;

    // Bitwise reduction over the terms; the seed is the identity of the outer
    // operator (0 for OR, all-ones for AND).
    always_comb begin
        red = {DW{mode}};
        for (int i = 0; i < N; i++) begin
            if (mode) begin
                red = red & (a[i*DW +: DW] | b[i*DW +: DW]);
            end else begin
                red = red | (a[i*DW +: DW] & b[i*DW +: DW]);
            end
        end
    end

    // rdy[k] is the ready seen by stage k (rdy[0] feeds the input). Stage k may
    // take data when the output is ready or any stage from k onward has a
    // bubble. Accumulating a running "all full" flag keeps the chain free of
    // self-referencing vector bits.
    always_comb begin
        rdy[STAGES] = out_ready;
        all_full    = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_full = all_full & v_q[k];
            rdy[k]   = out_ready | ~all_full;
        end
    end

    // Reset gating keeps the input closed while nreset is low; in_valid never
    // feeds in_ready.
    assign in_ready = rdy[0] & nreset;

    always_comb begin
        load    = '0;
        drain   = '0;
        din     = '0;
        load[0] = in_valid & in_ready;
        din[0]  = red;
        for (int j = 1; j < STAGES; j++) begin
            load[j] = v_q[j-1] & rdy[j];
            din[j]  = d_q[j-1];
        end
        for (int j = 0; j < STAGES; j++) begin
            drain[j] = v_q[j] & rdy[j+1];
        end
    end

    // A draining stage keeps its data; only the valid bit clears.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            v_q <= '0;
            d_q <= '0;
        end else begin
            for (int j = 0; j < STAGES; j++) begin
                if (load[j]) begin
                    v_q[j] <= 1'b1;
                    d_q[j] <= din[j];
                end else if (drain[j]) begin
                    v_q[j] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign z         = d_q[STAGES-1];

endmodule

// File: tb/tb_la_aopipe.sv
// Self-checking bench for la_aopipe: directed vectors and corner sequences on
// an N=3/DW=4/STAGES=2 instance, plus random sweeps over several shapes
// checked against a lane-counting reference model.
module tb_la_aopipe;

    int checks;
    int errors;

    logic        clk;
    logic        nreset;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [11:0] a;
    logic [11:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    la_aopipe #(
        .N     (3),
        .DW    (4),
        .STAGES(2),
        .PROP  ("MAIN")
    ) u_dut (
        .clk      (clk),
        .nreset   (nreset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .z        (z)
    );

    // Per lane: AO is set when at least one term has both bits set; OA is set
    // when every term has at least one bit set.
    function automatic logic [15:0] ref_red(input logic m, input logic [255:0] av,
                                            input logic [255:0] bv, input int n,
                                            input int dw);
        logic [15:0] r;
        int          cnt;
        r = '0;
        for (int l = 0; l < dw; l++) begin
            cnt = 0;
            for (int t = 0; t < n; t++) begin
                if (m) cnt += int'(av[t*dw+l] | bv[t*dw+l]);
                else   cnt += int'(av[t*dw+l] & bv[t*dw+l]);
            end
            r[l] = m ? (cnt == n) : (cnt != 0);
        end
        return r;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act,
                            input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rand();
        a    = 12'($urandom);
        b    = 12'($urandom);
        mode = 1'($urandom % 2);
    endtask

    // Scoreboard for the main instance, sampled on the falling edge.
    logic [3:0] m_exp[$];
    bit         m_stall;
    logic [3:0] m_zprev;
    logic [3:0] m_e;

    always @(negedge clk) begin
        if (!nreset) begin
            m_exp.delete();
            m_stall = 1'b0;
        end else begin
            if (m_stall) begin
                check_eq("main_stall_valid", 64'(out_valid), 64'(1));
                check_eq("main_stall_z", 64'(z), 64'(m_zprev));
            end
            if (out_valid && out_ready) begin
                if (m_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL main_extra_output: got z=%0h with no result pending", z);
                end else begin
                    m_e = m_exp.pop_front();
                    check_eq("main_z", 64'(z), 64'(m_e));
                end
            end
            if (in_valid && in_ready) begin
                m_exp.push_back(4'(ref_red(mode, 256'(a), 256'(b), 3, 4)));
            end
            m_stall = out_valid & ~out_ready;
            m_zprev = z;
        end
    end

    // Random sweep over other shapes.
    localparam int SwDw  = 3;
    localparam int SwCnt = 4;

    function automatic int sw_n(input int i);
        case (i)
            0:       return 1;
            1:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int sw_s(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    logic sw_nreset;

    initial begin
        sw_nreset = 1'b1;
        #1 sw_nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1 sw_nreset = 1'b1;
    end

    for (genvar gi = 0; gi < SwCnt; gi++) begin : g_sw
        localparam int Nn = sw_n(gi);
        localparam int Ss = sw_s(gi);

        logic              iv, ir, md, ov, ordy;
        logic [Nn*SwDw-1:0] aa, bb;
        logic [SwDw-1:0]   zz;
        logic [SwDw-1:0]   q_z[$];
        int                q_t[$];
        bit                q_p[$];
        int                cyc;
        bit                ph1;
        bit                stall;
        bit                done;
        bit                fire;
        bit                ep;
        int                et;
        logic [SwDw-1:0]   ez;
        logic [SwDw-1:0]   zprev;

        la_aopipe #(
            .N     (Nn),
            .DW    (SwDw),
            .STAGES(Ss),
            .PROP  ("SWEEP")
        ) u_dut (
            .clk      (clk),
            .nreset   (sw_nreset),
            .in_valid (iv),
            .in_ready (ir),
            .mode     (md),
            .a        (aa),
            .b        (bb),
            .out_valid(ov),
            .out_ready(ordy),
            .z        (zz)
        );

        initial begin
            done = 1'b0;
            fire = 1'b0;
            iv   = 1'b0;
            ordy = 1'b0;
            md   = 1'b0;
            aa   = '0;
            bb   = '0;
            ph1  = 1'b1;
            #2;
            wait (sw_nreset);
            @(posedge clk);
            #1;
            for (int c = 0; c < 450; c++) begin
                if (c == 150) ph1 = 1'b0;
                ordy = ph1 ? 1'b1 : 1'($urandom % 2);
                // A pending transaction is held until it is taken.
                if (fire || !iv) begin
                    iv = 1'($urandom % 2);
                    md = 1'($urandom % 2);
                    for (int k = 0; k < Nn*SwDw; k++) begin
                        aa[k] = 1'($urandom % 2);
                        bb[k] = 1'($urandom % 2);
                    end
                end
                #2;
                fire = iv & ir;
                @(posedge clk);
                #1;
            end
            iv   = 1'b0;
            ordy = 1'b1;
            repeat (2*Ss + 4) begin
                @(posedge clk);
                #1;
            end
            check_eq($sformatf("sw%0d_drained", gi), 64'(q_z.size()), 64'(0));
            done = 1'b1;
        end

        always @(negedge clk) begin
            if (!sw_nreset) begin
                q_z.delete();
                q_t.delete();
                q_p.delete();
                stall = 1'b0;
                cyc   = 0;
            end else begin
                cyc++;
                if (stall) begin
                    check_eq($sformatf("sw%0d_stall_valid", gi), 64'(ov), 64'(1));
                    check_eq($sformatf("sw%0d_stall_z", gi), 64'(zz), 64'(zprev));
                end
                if (ov && ordy) begin
                    if (q_z.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sw%0d_extra_output: got z=%0h with no result pending",
                                 gi, zz);
                    end else begin
                        ez = q_z.pop_front();
                        et = q_t.pop_front();
                        ep = q_p.pop_front();
                        check_eq($sformatf("sw%0d_z", gi), 64'(zz), 64'(ez));
                        if (ep && ph1) begin
                            check_eq($sformatf("sw%0d_latency", gi), 64'(cyc - et), 64'(Ss));
                        end else begin
                            check_eq($sformatf("sw%0d_latency_min", gi),
                                     64'((cyc - et) >= Ss), 64'(1));
                        end
                    end
                end
                if (iv && ir) begin
                    q_z.push_back(SwDw'(ref_red(md, 256'(aa), 256'(bb), Nn, SwDw)));
                    q_t.push_back(cyc);
                    q_p.push_back(ph1);
                end
                stall = ov & ~ordy;
                zprev = zz;
            end
        end
    end

    typedef struct {
        logic        m;
        logic [11:0] a;
        logic [11:0] b;
        logic [3:0]  z;
    } vec_t;

    vec_t        vecs[8];
    logic [11:0] pat;

    initial begin
        checks    = 0;
        errors    = 0;
        nreset    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 1'b0;
        a         = '0;
        b         = '0;

        vecs[0] = '{1'b0, 12'hF35, 12'h1FA, 4'h3};
        vecs[1] = '{1'b1, 12'hF35, 12'h1FA, 4'hF};
        vecs[2] = '{1'b1, 12'hFFF, 12'h000, 4'hF};
        vecs[3] = '{1'b0, 12'h000, 12'hFFF, 4'h0};
        vecs[4] = '{1'b1, 12'h000, 12'h000, 4'h0};
        vecs[5] = '{1'b0, 12'h123, 12'hFFF, 4'h3};
        vecs[6] = '{1'b1, 12'h124, 12'h812, 4'h0};
        vecs[7] = '{1'b0, 12'hC96, 12'h6F3, 4'hF};

        // Asynchronous reset before any clock edge, with in_valid asserted.
        #1 nreset = 1'b0;
        in_valid = 1'b1;
        #2;
        check_eq("rst_async_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_async_z", 64'(z), 64'(0));
        check_eq("rst_async_in_ready", 64'(in_ready), 64'(0));
        step();
        step();
        check_eq("rst_hold_in_ready", 64'(in_ready), 64'(0));
        check_eq("rst_hold_out_valid", 64'(out_valid), 64'(0));
        nreset   = 1'b1;
        in_valid = 1'b0;
        #1;
        check_eq("rst_release_in_ready", 64'(in_ready), 64'(1));

        // Single transactions: latency exactly 2 with out_ready high.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mode     = vecs[i].m;
            a        = vecs[i].a;
            b        = vecs[i].b;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check_eq($sformatf("tbl%0d_lat1_valid", i), 64'(out_valid), 64'(0));
            step();
            check_eq($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(1));
            check_eq($sformatf("tbl%0d_z", i), 64'(z), 64'(vecs[i].z));
            step();
            check_eq($sformatf("tbl%0d_drain", i), 64'(out_valid), 64'(0));
        end

        // Eight back-to-back transactions.
        pat = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k <= 8) begin
                set_rand();
                in_valid = 1'b1;
                #1;
                check_eq("b2b_in_ready", 64'(in_ready), 64'(1));
            end else begin
                in_valid = 1'b0;
            end
            step();
            pat[k-1] = out_valid;
        end
        check_eq("b2b_valid_pattern", 64'(pat), 64'(12'h1FE));

        // Backpressure: fill, stall, release.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_rand();
            in_valid = 1'b1;
            #1;
            check_eq("bp_in_ready_fill", 64'(in_ready), 64'(1));
            step();
        end
        set_rand();
        #1;
        check_eq("bp_in_ready_full", 64'(in_ready), 64'(0));
        check_eq("bp_out_valid_full", 64'(out_valid), 64'(1));
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("bp_in_ready_stall", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_in_ready_release", 64'(in_ready), 64'(1));
        step();
        for (int i = 0; i < 3; i++) begin
            set_rand();
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        check_eq("bp_drained", 64'(m_exp.size()), 64'(0));

        // Reset with two results in flight.
        out_ready = 1'b0;
        mode      = vecs[2].m;
        a         = vecs[2].a;
        b         = vecs[2].b;
        in_valid  = 1'b1;
        step();
        mode = vecs[0].m;
        a    = vecs[0].a;
        b    = vecs[0].b;
        step();
        in_valid = 1'b0;
        #1;
        check_eq("midrst_pre_valid", 64'(out_valid), 64'(1));
        check_eq("midrst_pre_z", 64'(z), 64'(4'hF));
        nreset = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
        check_eq("midrst_z", 64'(z), 64'(0));
        check_eq("midrst_in_ready", 64'(in_ready), 64'(0));
        step();
        check_eq("midrst_hold_valid", 64'(out_valid), 64'(0));
        nreset    = 1'b1;
        out_ready = 1'b1;
        mode      = vecs[0].m;
        a         = vecs[0].a;
        b         = vecs[0].b;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("postrst_lat1_valid", 64'(out_valid), 64'(0));
        step();
        check_eq("postrst_valid", 64'(out_valid), 64'(1));
        check_eq("postrst_z", 64'(z), 64'(vecs[0].z));
        step();

        for (int i = 0; i < 3000; i++) begin
            if (g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) break;
            step();
        end
        if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done)) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout: got incomplete sweep, expected all sweeps done");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
